// File: rtl/mult_div_unit_pkg.sv
// mult_div_unit_pkg
// Shared definitions for the HI/LO multiply/divide unit and the decoder.
//   md_op encodings: MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO
//   FSM state encodings for the unit's controller.
//   is_arith_op(): true for the ops that open a multi-cycle busy window.
package mult_div_unit_pkg;

    localparam logic [2:0] MD_MULT  = 3'd0;
    localparam logic [2:0] MD_MULTU = 3'd1;
    localparam logic [2:0] MD_DIV   = 3'd2;
    localparam logic [2:0] MD_DIVU  = 3'd3;
    localparam logic [2:0] MD_MTHI  = 3'd4;
    localparam logic [2:0] MD_MTLO  = 3'd5;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_BUSY  = 1'b1;

    function automatic logic is_arith_op(input logic [2:0] op);
        return (op <= MD_DIVU);
    endfunction

endpackage

// File: rtl/md_arith.sv
// md_arith
// Combinational 64-bit {hi,lo} result for mult/multu/div/divu.
// A divide by zero returns the current {hi,lo} so the later commit is a no-op.
// Ports:
//   md_op   in  3   operation select
//   rs_val  in  32  rs operand (dividend / multiplicand)
//   rt_val  in  32  rt operand (divisor / multiplier)
//   hi_cur  in  32  current HI, used for the divide-by-zero hold
//   lo_cur  in  32  current LO, used for the divide-by-zero hold
//   result  out 64  {hi,lo} to be committed
module md_arith
    import mult_div_unit_pkg::*;
(
    input  logic [2:0]  md_op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic [31:0] hi_cur,
    input  logic [31:0] lo_cur,
    output logic [63:0] result
);

    logic signed [63:0] prod_s;
    logic        [63:0] prod_u;
    logic signed [31:0] quot_s;
    logic signed [31:0] rem_s;
    logic        [31:0] quot_u;
    logic        [31:0] rem_u;
    logic               div_zero;

    assign div_zero = (rt_val == 32'd0);

    assign prod_s = $signed({{32{rs_val[31]}}, rs_val}) * $signed({{32{rt_val[31]}}, rt_val});
    assign prod_u = {32'd0, rs_val} * {32'd0, rt_val};

    // Guard the divider inputs so a zero divisor never reaches the operator.
    assign quot_s = div_zero ? 32'sd0 : ($signed(rs_val) / $signed(rt_val));
    assign rem_s  = div_zero ? 32'sd0 : ($signed(rs_val) % $signed(rt_val));
    assign quot_u = div_zero ? 32'd0  : (rs_val / rt_val);
    assign rem_u  = div_zero ? 32'd0  : (rs_val % rt_val);

    always_comb begin
        result = {hi_cur, lo_cur};
        case (md_op)
            MD_MULT:  result = prod_s;
            MD_MULTU: result = prod_u;
            MD_DIV:   if (!div_zero) result = {rem_s, quot_s};
            MD_DIVU:  if (!div_zero) result = {rem_u, quot_u};
            default:  result = {hi_cur, lo_cur};
        endcase
    end

endmodule

// File: rtl/mult_div_unit.sv
// mult_div_unit
// E-stage HI/LO multiply/divide unit. Arithmetic ops are computed at launch,
// held in pending registers, and committed to HI/LO when the fixed busy
// window expires. mthi/mtlo write HI/LO directly at the next edge.
// Optional build macro: MDU_CANCEL_EN adds a cancel input that aborts an
// operation in flight and suppresses a same-cycle launch or mt write.
// Ports:
//   clk      in   1   clock, rising edge
//   reset_n  in   1   asynchronous active-low reset
//   cancel   in   1   (MDU_CANCEL_EN only) abort / suppress
//   start    in   1   mult/multu/div/divu present in E
//   use_md   in   1   E-stage instruction touches HI/LO
//   md_op    in   3   operation select (see mult_div_unit_pkg)
//   rs_val   in   32  forwarded rs
//   rt_val   in   32  forwarded rt
//   busy     out  1   operation in flight (registered)
//   hi       out  32  HI register
//   lo       out  32  LO register
//
// state   | meaning
// --------+------------------------------------------------
// ST_IDLE | accepting launches and mt writes
// ST_BUSY | counting down; pending result commits at cnt==1
module mult_div_unit
    import mult_div_unit_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 4
) (
    input  logic        clk,
    input  logic        reset_n,
`ifdef MDU_CANCEL_EN
    input  logic        cancel,
`endif
    input  logic        start,
    input  logic        use_md,
    input  logic [2:0]  md_op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    logic [0:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [31:0]      pend_hi;
    logic [31:0]      pend_lo;
    logic [63:0]      result;
    logic             cancel_w;
    logic             idle;
    logic             launch;
    logic             mt_hi;
    logic             mt_lo;
    logic             is_mult;

`ifdef MDU_CANCEL_EN
    assign cancel_w = cancel;
`else
    assign cancel_w = 1'b0;
`endif

    md_arith u_arith (
        .md_op  (md_op),
        .rs_val (rs_val),
        .rt_val (rt_val),
        .hi_cur (hi),
        .lo_cur (lo),
        .result (result)
    );

    assign idle    = (state == ST_IDLE);
    assign launch  = idle & start & is_arith_op(md_op) & ~cancel_w;
    assign mt_hi   = idle & use_md & ~start & (md_op == MD_MTHI) & ~cancel_w;
    assign mt_lo   = idle & use_md & ~start & (md_op == MD_MTLO) & ~cancel_w;
    assign is_mult = (md_op == MD_MULT) || (md_op == MD_MULTU);

    // busy comes straight from the state flop, so it cannot glitch.
    assign busy = (state == ST_BUSY);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            pend_hi <= '0;
            pend_lo <= '0;
            hi      <= '0;
            lo      <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (launch) begin
                        state   <= ST_BUSY;
                        cnt     <= is_mult ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
                        pend_hi <= result[63:32];
                        pend_lo <= result[31:0];
                    end else if (mt_hi) begin
                        hi <= rs_val;
                    end else if (mt_lo) begin
                        lo <= rs_val;
                    end
                end
                ST_BUSY: begin
                    // Cancel wins over a completion on the same edge.
                    if (cancel_w) begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                    end else if (cnt == CNT_W'(1)) begin
                        hi    <= pend_hi;
                        lo    <= pend_lo;
                        state <= ST_IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule
